// File: rtl/instruction_fetch_if.sv
// Instruction memory bus between the fetch stage and a combinational instruction memory.
// The fetch stage drives the address, and the memory returns the word in the same cycle.
interface instruction_fetch_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;

   modport master (output imem_addr, input imem_instr);
   modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/instruction_fetch.sv
// IF stage: PC register, redirect/stall next-PC selection, IF/ID pipeline register
// and delivered-instruction / stall-cycle counters.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h00400000,
   parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
   input  logic                 clk,
   input  logic                 reset,
   instruction_fetch_if.master  imem,
   input  logic                 stall_if,
   input  logic                 branch_taken,
   input  logic [31:0]          branch_target,
   input  logic                 jump,
   input  logic [31:0]          jump_target,
   input  logic                 exception,
   output logic [31:0]          pc,
   output logic [31:0]          id_instr,
   output logic [31:0]          id_pc_plus4,
   output logic                 id_valid,
   output logic [31:0]          fetch_count,
   output logic [31:0]          stall_count
);

   logic        redirect;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc_raw;
   logic [31:0] next_pc;

   assign imem.imem_addr = pc;
   assign pc_plus4       = pc + 32'd4;
   assign redirect       = exception | branch_taken | jump;

   always_comb begin
      next_pc_raw = pc_plus4;
      if (exception)         next_pc_raw = EXC_VECTOR;
      else if (branch_taken) next_pc_raw = branch_target;
      else if (jump)         next_pc_raw = jump_target;
      else if (stall_if)     next_pc_raw = pc;
   end

   // Every value loaded into pc is word aligned, whatever the target's low bits were.
   assign next_pc = {next_pc_raw[31:2], 2'b00};

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= {RESET_PC[31:2], 2'b00};
         id_instr    <= '0;
         id_pc_plus4 <= '0;
         id_valid    <= 1'b0;
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         pc <= next_pc;
         if (redirect) begin
            id_instr    <= '0;
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
         end else if (stall_if) begin
            stall_count <= stall_count + 32'd1;
         end else begin
            id_instr    <= imem.imem_instr;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule
